// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: PC width, 2-bit counter encodings
// and the sequential next-PC helper.
package branch_predictor_pkg;

  localparam int PC_W = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  function automatic logic [PC_W-1:0] seq_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup, update and statistics signals between the pipeline and the branch predictor.
interface branch_predictor_if #(parameter int CNT_W = 32);
  import branch_predictor_pkg::*;

  // if_valid qualifies pc_if and upd_en qualifies the upd_* group; both are
  // accepted every cycle they are high (no ready/backpressure on either side).
  logic [PC_W-1:0]  pc_if;
  logic             if_valid;
  logic             predict;
  logic [PC_W-1:0]  predict_target;
  logic             upd_en;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic             upd_pred;
  logic             mispredict;
  logic [CNT_W-1:0] stat_lookups;
  logic [CNT_W-1:0] stat_updates;
  logic [CNT_W-1:0] stat_mispred;

  modport master (
    output pc_if, if_valid, upd_en, upd_pc, upd_taken, upd_target, upd_pred,
    input  predict, predict_target, mispredict, stat_lookups, stat_updates, stat_mispred
  );

  modport slave (
    input  pc_if, if_valid, upd_en, upd_pc, upd_taken, upd_target, upd_pred,
    output predict, predict_target, mispredict, stat_lookups, stat_updates, stat_mispred
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state of a 2-bit saturating branch counter; init reloads a fresh entry
// to the weak state matching the outcome instead of stepping the old value.
module bp_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  input  logic       init,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (init) begin
      nxt = taken ? WT : WNT;
    end else if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BHT of 2-bit counters plus direct-mapped BTB, looked up
// combinationally from IF and trained from the MEM-stage resolution.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bus
);

  localparam int DEPTH = 1 << IDX_W;

  logic             valid_q [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [1:0]       cnt_q   [DEPTH];
  logic [PC_W-3:0]  tgt_q   [DEPTH];

  logic             mispredict_q;
  logic [CNT_W-1:0] lookups_q;
  logic [CNT_W-1:0] updates_q;
  logic [CNT_W-1:0] mispred_q;

  // Lookup reads the table contents as of the start of the cycle, so a same-cycle
  // update to the same index is seen only from the next cycle.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_predict;

  assign lk_idx     = bus.pc_if[IDX_W+1:2];
  assign lk_tag     = bus.pc_if[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_predict = bus.if_valid & ~reset & lk_hit & cnt_q[lk_idx][1];

  assign bus.predict        = lk_predict;
  assign bus.predict_target = lk_predict ? {tgt_q[lk_idx], 2'b00} : seq_next(bus.pc_if);

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       cnt_next;

  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  bp_sat_counter2 u_sat (
    .cur   (cnt_q[upd_idx]),
    .taken (bus.upd_taken),
    .init  (~upd_hit),
    .nxt   (cnt_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= WNT;
        tgt_q[i]   <= '0;
      end
      mispredict_q <= 1'b0;
      lookups_q    <= '0;
      updates_q    <= '0;
      mispred_q    <= '0;
    end else begin
      if (bus.upd_en) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        cnt_q[upd_idx]   <= cnt_next;
        if (bus.upd_taken) tgt_q[upd_idx] <= bus.upd_target[PC_W-1:2];
        updates_q <= updates_q + CNT_W'(1);
        if (bus.upd_pred != bus.upd_taken) mispred_q <= mispred_q + CNT_W'(1);
      end
      mispredict_q <= bus.upd_en & (bus.upd_pred != bus.upd_taken);
      if (bus.if_valid) lookups_q <= lookups_q + CNT_W'(1);
    end
  end

  assign bus.mispredict   = mispredict_q;
  assign bus.stat_lookups = lookups_q;
  assign bus.stat_updates = updates_q;
  assign bus.stat_mispred = mispred_q;

  // Bits outside the index/tag window of the update PC and the byte offset of the target.
  logic unused_bits;
  assign unused_bits = ^{bus.upd_pc[1:0], bus.upd_pc[PC_W-1:IDX_W+TAG_W+2], bus.upd_target[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor with a table-level reference model
// and a queue-based scoreboard checked by an independent monitor.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic reset;

  branch_predictor_if #(.CNT_W(32)) bus ();

  branch_predictor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];   // {predict, predict_target} per qualified lookup
  logic [96:0] st_q[$];    // {mispredict, lookups, updates, mispred} after each edge

  bit          m_valid [64];
  int          m_tag   [64];
  int          m_cnt   [64];
  logic [31:0] m_tgt   [64];
  logic        m_misp;
  logic [31:0] m_lk, m_up, m_mp;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> 8) % 256);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_cnt[i]   = 1;
      m_tgt[i]   = 32'h0;
    end
    m_misp = 1'b0;
    m_lk = 0;
    m_up = 0;
    m_mp = 0;
  endtask

  // Drives one cycle of inputs, records expectations, and advances past the edge.
  task automatic cycle(input logic rst, input logic [31:0] pc, input logic ifv,
                       input logic ue, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic up);
    int  i;
    int  j;
    bit  p;
    reset          = rst;
    bus.pc_if      = pc;
    bus.if_valid   = ifv;
    bus.upd_en     = ue;
    bus.upd_pc     = upc;
    bus.upd_taken  = ut;
    bus.upd_target = utg;
    bus.upd_pred   = up;
    if (ifv) begin
      i = idx_of(pc);
      p = !rst && m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= 2);
      exp_q.push_back({p, p ? m_tgt[i] : pc + 32'd4});
    end
    if (rst) begin
      model_reset();
    end else begin
      if (ifv) m_lk = m_lk + 1;
      m_misp = ue && (up != ut);
      if (ue) begin
        j = idx_of(upc);
        m_up = m_up + 1;
        if (up != ut) m_mp = m_mp + 1;
        if (m_valid[j] && m_tag[j] == tag_of(upc))
          m_cnt[j] = ut ? ((m_cnt[j] == 3) ? 3 : m_cnt[j] + 1)
                        : ((m_cnt[j] == 0) ? 0 : m_cnt[j] - 1);
        else
          m_cnt[j] = ut ? 2 : 1;
        m_valid[j] = 1;
        m_tag[j]   = tag_of(upc);
        if (ut) m_tgt[j] = utg & 32'hFFFF_FFFC;
      end
    end
    @(posedge clk);
    #1;
    st_q.push_back({m_misp, m_lk, m_up, m_mp});
  endtask

  task automatic look(input logic [31:0] pc);
    cycle(1'b0, pc, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg, input logic pr);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, pc, t, tg, pr);
  endtask

  logic [32:0] lk_exp;
  logic [96:0] st_exp;

  always @(negedge clk) begin
    if (bus.if_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL lookup_unexpected pc=%h got=%b/%h required=no lookup", bus.pc_if, bus.predict, bus.predict_target);
      end else begin
        lk_exp = exp_q.pop_front();
        if ({bus.predict, bus.predict_target} !== lk_exp) begin
          errors++;
          $display("FAIL lookup pc=%h got=%b/%h required=%b/%h", bus.pc_if,
                   bus.predict, bus.predict_target, lk_exp[32], lk_exp[31:0]);
        end
      end
    end
    if (st_q.size() > 0) begin
      st_exp = st_q.pop_front();
      checks++;
      if ({bus.mispredict, bus.stat_lookups, bus.stat_updates, bus.stat_mispred} !== st_exp) begin
        errors++;
        $display("FAIL status got=%b/%0d/%0d/%0d required=%b/%0d/%0d/%0d",
                 bus.mispredict, bus.stat_lookups, bus.stat_updates, bus.stat_mispred,
                 st_exp[96], st_exp[95:64], st_exp[63:32], st_exp[31:0]);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] pc;
    reset = 1'b1;
    bus.pc_if = '0;
    bus.if_valid = 1'b0;
    bus.upd_en = 1'b0;
    bus.upd_pc = '0;
    bus.upd_taken = 1'b0;
    bus.upd_target = '0;
    bus.upd_pred = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset, then a cold lookup.
    cycle(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look(32'h40);

    // Taken training, then saturating not-taken walk down.
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    cycle(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1);
    look(32'h40);
    upd(32'h40, 1'b0, 32'h0, 1'b1);
    look(32'h40);
    upd(32'h40, 1'b0, 32'h0, 1'b1);
    look(32'h40);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40);

    // Alias on the same index with a different tag.
    upd(32'h40, 1'b1, 32'h200, 1'b0);
    upd(32'h40, 1'b1, 32'h200, 1'b1);
    look(32'h40);
    look(32'h1040);
    upd(32'h1040, 1'b0, 32'h0, 1'b0);
    look(32'h1040);
    look(32'h40);

    // Same-cycle lookup and update: old entry seen, new one next cycle.
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b1, 32'h300, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h303, 1'b0);
    look(32'h40);

    // Reset wins over a concurrent update.
    cycle(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h500, 1'b1);
    look(32'h40);
    upd(32'h40, 1'b0, 32'h0, 1'b1);
    look(32'h40);

    // Random traffic over a few indices and tags so hits, aliases and saturation all occur.
    for (int n = 0; n < 800; n++) begin
      pc = $urandom;
      pc[15:2] = {6'($urandom_range(0, 2)), 6'h0, 2'($urandom_range(0, 3))};
      cycle(($urandom_range(0, 99) == 0),
            {$urandom_range(0, 1) == 1 ? pc[31:16] : 16'h0, 2'($urandom_range(0, 2)), 6'h0, 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))},
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0),
            pc, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    bus.if_valid = 1'b0;
    bus.upd_en = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d pending required=0/0", exp_q.size(), st_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
